// File: rtl/mmio_console.sv
// mmio_console: memory-mapped transmit-only serial console with an 8-byte FIFO.
// Define MMIO_CONSOLE_PARITY_EN to add an even-parity bit (11-bit 8E1 frame).
module mmio_console #(
  parameter logic [31:0] BASE_ADDR    = 32'h1002_0000,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef MMIO_CONSOLE_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic        overflow;
  logic        enable;
  logic        irq_en;

  logic [2:0]  state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
`ifdef MMIO_CONSOLE_PARITY_EN
  logic        parity;
`endif

  logic        hit;
  logic [1:0]  sel;
  logic        full;
  logic        empty;
  logic        busy;
  logic        bit_done;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        clr_ovf;
  logic        ctrl_we;
  logic [7:0]  head;
  logic        unused_bits;

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel      = addr[3:2];
  assign full     = (count == 4'd8);
  assign empty    = (count == 4'd0);
  assign busy     = (state != ST_IDLE);
  assign bit_done = (bit_cnt == BIT_LAST);
  assign head     = fifo_mem[rd_ptr];

  assign push_req = we && hit && (sel == 2'd0);
  assign push     = push_req && !full;
  assign clr_ovf  = we && hit && (sel == 2'd1) && wdata[3];
  assign ctrl_we  = we && hit && (sel == 2'd2);

  // A pop happens exactly when a new frame is loaded: from IDLE, or from the
  // last STOP cycle for back-to-back frames.
  assign pop = enable && !empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  assign irq = empty && (state == ST_IDLE) && irq_en;

  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        2'd1:    rdata = {20'b0, count, 4'b0, overflow, busy, empty, full};
        2'd2:    rdata = {30'b0, irq_en, enable};
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (push_req && full) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
      if (ctrl_we) begin
        enable <= wdata[0];
        irq_en <= wdata[1];
      end
    end
  end

  // txd is assigned alongside each state change so the line is always a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
`ifdef MMIO_CONSOLE_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            state  <= ST_START;
            shift  <= head;
            txd    <= 1'b0;
`ifdef MMIO_CONSOLE_PARITY_EN
            parity <= ^head;
`endif
          end
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_CONSOLE_PARITY_EN
              state <= ST_PARITY;
              txd   <= parity;
`else
              state <= ST_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`ifdef MMIO_CONSOLE_PARITY_EN
        ST_PARITY: begin
          if (bit_done) begin
            state   <= ST_STOP;
            bit_cnt <= '0;
            txd     <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (pop) begin
              state  <= ST_START;
              shift  <= head;
              txd    <= 1'b0;
`ifdef MMIO_CONSOLE_PARITY_EN
              parity <= ^head;
`endif
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
          txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule
